// File: rtl/io_mmap.sv
// CPU-side memory-mapped I/O bridge: splits accesses between RAM and the I/O window,
// buffers UART TX/RX bytes and keeps the cycle counter and stop flag.

module io_mmap_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic [AW:0] count,
    output logic [AW:0] count_nxt,
    output logic        drop
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  full, accept;

    // count is AW+1 bits, so its MSB alone marks "full"
    assign full   = count[AW];
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    assign head   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (accept && !pop)
            count_nxt = count + 1'b1;
        else if (!accept && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end
endmodule

module io_mmap #(
    parameter int TX_AW       = 4,
    parameter int RX_AW       = 3,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_finish,
    output logic        tx_overflow,
    output logic        rx_overflow
);
    localparam logic [17:0]    A_UART      = 18'h30000;
    localparam logic [17:0]    A_CTRL      = 18'h30004;
    localparam logic [TX_AW:0] FULL_THRESH = (TX_AW+1)'((1 << TX_AW) - FULL_MARGIN);

    logic [17:0]    a;
    logic           io, acc_io, io_rd;
    logic           tx_push, tx_pop, tx_drop;
    logic [7:0]     tx_push_data;
    logic [TX_AW:0] tx_count, tx_count_nxt;
    logic           rx_pop, rx_drop;
    logic [7:0]     rx_head;
    logic [RX_AW:0] rx_count, unused_rx_count_nxt;
    logic [7:0]     rdata_nxt;
    logic [31:0]    counter, snap;
    logic           sel_io_q;
    logic [7:0]     io_rdata_q;
    logic           unused_addr;

    assign unused_addr = ^cpu_a[31:18];
    assign a           = cpu_a[17:0];
    assign io          = (a[17:16] == 2'b11);
    assign acc_io      = rdy_in & io;
    assign io_rd       = acc_io & ~cpu_wr;

    assign ram_a    = cpu_a[16:0];
    assign ram_wr   = cpu_wr & ~io & rdy_in;
    assign ram_dout = cpu_dout;
    assign cpu_din  = sel_io_q ? io_rdata_q : ram_din;

    // the stop write pushes a literal 0x00, bypassing the zero filter on the data port
    assign tx_push      = acc_io & cpu_wr &
                          (((a == A_UART) && (cpu_dout != 8'h00)) || (a == A_CTRL));
    assign tx_push_data = (a == A_CTRL) ? 8'h00 : cpu_dout;
    assign tx_valid     = (tx_count != '0);
    assign tx_pop       = tx_valid & tx_ready;
    assign rx_pop       = io_rd & (a == A_UART) & (rx_count != '0);

    always_comb begin
        rdata_nxt = 8'h00;
        case (a)
            A_UART:       rdata_nxt = (rx_count != '0) ? rx_head : 8'h00;
            A_CTRL:       rdata_nxt = counter[7:0];
            18'h30005:    rdata_nxt = snap[15:8];
            18'h30006:    rdata_nxt = snap[23:16];
            18'h30007:    rdata_nxt = snap[31:24];
            default:      rdata_nxt = 8'h00;
        endcase
    end

    io_mmap_fifo #(.AW(TX_AW)) u_tx (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_data),
        .count     (tx_count),
        .count_nxt (tx_count_nxt),
        .drop      (tx_drop)
    );

    io_mmap_fifo #(.AW(RX_AW)) u_rx (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .count_nxt (unused_rx_count_nxt),
        .drop      (rx_drop)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            counter        <= '0;
            snap           <= '0;
            sel_io_q       <= 1'b0;
            io_rdata_q     <= '0;
            program_finish <= 1'b0;
            tx_overflow    <= 1'b0;
            rx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            counter        <= counter + 32'd1;
            io_buffer_full <= (tx_count_nxt >= FULL_THRESH);
            if (acc_io && cpu_wr && (a == A_CTRL)) program_finish <= 1'b1;
            if (tx_drop) tx_overflow <= 1'b1;
            if (rx_drop) rx_overflow <= 1'b1;
            if (rdy_in)  sel_io_q    <= io & ~cpu_wr;
            if (io_rd)   io_rdata_q  <= rdata_nxt;
            // byte 0 comes live; the snapshot keeps bytes 1..3 coherent with it
            if (io_rd && (a == A_CTRL)) snap <= counter;
        end
    end
endmodule

// File: tb/tb_io_mmap.sv
// Directed bench for io_mmap: TX/RX FIFOs, counter snapshot, stop flag, read mux, reset.

module tb_io_mmap;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] cpu_a = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        program_finish;
    logic        tx_overflow;
    logic        rx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    io_mmap dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .ram_dout       (ram_dout),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_finish (program_finish),
        .tx_overflow    (tx_overflow),
        .rx_overflow    (rx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic set_idle();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        rdy_in   = 1'b1;
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [7:0] d);
        cpu_a = addr; cpu_wr = 1'b1; cpu_dout = d; rdy_in = 1'b1;
        @(negedge clk_in);
        set_idle();
    endtask

    task automatic io_read(input logic [31:0] addr);
        cpu_a = addr; cpu_wr = 1'b0; rdy_in = 1'b1;
        @(negedge clk_in);
        set_idle();
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    // Leaves the bench at a negedge just after release: the counter is 0 there.
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        set_idle();
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        ram_din = 8'h5A;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_buf_full: got %b want 0", io_buffer_full); end
        n_checks++; if (program_finish !== 1'b0) begin n_fail++; $display("FAIL rst_finish: got %b want 0", program_finish); end
        n_checks++; if ({tx_overflow, rx_overflow} !== 2'b00) begin n_fail++; $display("FAIL rst_overflow: got %b want 00", {tx_overflow, rx_overflow}); end
        n_checks++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL rst_cpu_din: got %h want 5a", cpu_din); end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL post_rst_cpu_din: got %h want 5a", cpu_din); end
    endtask

    task automatic test_tx();
        tx_ready = 1'b1;
        io_write(32'h30000, 8'h41);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_push: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data_push: got %h want 41", tx_data); end
        @(negedge clk_in);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_valid_pop: got %b want 0", tx_valid); end
        io_write(32'h30000, 8'h00);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_zero_filter: got %b want 0", tx_valid); end
        io_write(32'h30001, 8'h66);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_other_addr: got %b want 0", tx_valid); end
    endtask

    task automatic test_tx_full();
        int n;
        int bad;
        tx_ready = 1'b0;
        for (int i = 0; i < 13; i++) io_write(32'h30000, 8'h55);
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL buf_full_13: got %b want 0", io_buffer_full); end
        io_write(32'h30000, 8'h55);
        n_checks++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL buf_full_14: got %b want 1", io_buffer_full); end
        io_write(32'h30000, 8'h55);
        io_write(32'h30000, 8'h55);
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_16: got %b want 0", tx_overflow); end
        io_write(32'h30000, 8'h55);
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_17: got %b want 1", tx_overflow); end
        tx_ready = 1'b1;
        n = 0; bad = 0;
        while (tx_valid && n < 40) begin
            if (tx_data !== 8'h55) bad++;
            n++;
            @(negedge clk_in);
        end
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL tx_drain_count: got %0d want 16", n); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tx_drain_data: got %0d bad bytes want 0", bad); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL buf_full_drained: got %b want 0", io_buffer_full); end
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_sticky: got %b want 1", tx_overflow); end
    endtask

    task automatic test_rx();
        ram_din = 8'hA5;
        rx_push(8'h31);
        rx_push(8'h32);
        io_read(32'h30000);
        n_checks++; if (cpu_din !== 8'h31) begin n_fail++; $display("FAIL rx_read1: got %h want 31", cpu_din); end
        io_read(32'h30000);
        n_checks++; if (cpu_din !== 8'h32) begin n_fail++; $display("FAIL rx_read2: got %h want 32", cpu_din); end
        io_read(32'h30000);
        n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rx_read_empty: got %h want 00", cpu_din); end
        @(negedge clk_in);
        n_checks++; if (cpu_din !== 8'hA5) begin n_fail++; $display("FAIL rx_back_to_ram: got %h want a5", cpu_din); end
        for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
        n_checks++; if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL rx_ovf: got %b want 1", rx_overflow); end
        for (int i = 0; i < 9; i++) begin
            io_read(32'h30000);
            n_checks++;
            if (cpu_din !== ((i < 8) ? 8'h10 + 8'(i) : 8'h00)) begin
                n_fail++; $display("FAIL rx_fill_read%0d: got %h want %h", i, cpu_din, (i < 8) ? 8'h10 + 8'(i) : 8'h00);
            end
        end
    endtask

    task automatic test_rdy_low();
        tx_ready = 1'b0;
        cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h77; rdy_in = 1'b0;
        @(negedge clk_in);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_low_tx_push: got %b want 0", tx_valid); end
        cpu_a = 32'h00100;
        #1;
        n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL rdy_low_ram_wr: got %b want 0", ram_wr); end
        set_idle();
        rx_push(8'h44);
        cpu_a = 32'h30000; cpu_wr = 1'b0; rdy_in = 1'b0;
        repeat (2) @(negedge clk_in);
        io_read(32'h30000);
        n_checks++; if (cpu_din !== 8'h44) begin n_fail++; $display("FAIL rdy_low_no_pop: got %h want 44", cpu_din); end
    endtask

    task automatic test_finish();
        tx_ready = 1'b0;
        ram_din  = 8'hC3;
        n_checks++; if (program_finish !== 1'b0) begin n_fail++; $display("FAIL finish_pre: got %b want 0", program_finish); end
        io_write(32'h30004, 8'h99);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL finish_tx_valid: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL finish_tx_data: got %h want 00", tx_data); end
        n_checks++; if (program_finish !== 1'b1) begin n_fail++; $display("FAIL finish_set: got %b want 1", program_finish); end
        tx_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL finish_drained: got %b want 0", tx_valid); end
        n_checks++; if (program_finish !== 1'b1) begin n_fail++; $display("FAIL finish_sticky: got %b want 1", program_finish); end
        io_read(32'h30000);
        n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL io_read_empty: got %h want 00", cpu_din); end
        cpu_a = 32'h00100; cpu_wr = 1'b0;
        #1;
        n_checks++; if (ram_a !== 17'h00100) begin n_fail++; $display("FAIL ram_a: got %h want 00100", ram_a); end
        n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL ram_wr_read: got %b want 0", ram_wr); end
        @(negedge clk_in);
        n_checks++; if (cpu_din !== 8'hC3) begin n_fail++; $display("FAIL ram_read_din: got %h want c3", cpu_din); end
        cpu_wr = 1'b1; cpu_dout = 8'h3C;
        #1;
        n_checks++; if ({ram_wr, ram_dout} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL ram_write: got %b/%h want 1/3c", ram_wr, ram_dout); end
        cpu_a = 32'h30004;
        #1;
        n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL ram_wr_io: got %b want 0", ram_wr); end
        set_idle();
        @(negedge clk_in);
    endtask

    task automatic test_counter();
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        exp1 = '{8'h64, 8'h00, 8'h00, 8'h00};
        exp2 = '{8'hFF, 8'h00, 8'h00, 8'h00};
        do_reset();
        repeat (100) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            io_read(32'h30004 + i);
            n_checks++; if (cpu_din !== exp1[i]) begin n_fail++; $display("FAIL cnt100_byte%0d: got %h want %h", i, cpu_din, exp1[i]); end
        end
        do_reset();
        repeat (255) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            io_read(32'h30004 + i);
            n_checks++; if (cpu_din !== exp2[i]) begin n_fail++; $display("FAIL cnt255_byte%0d: got %h want %h", i, cpu_din, exp2[i]); end
        end
        io_read(32'h30008);
        n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL io_other_read: got %h want 00", cpu_din); end
    endtask

    task automatic test_mid_reset();
        tx_ready = 1'b0;
        io_write(32'h30004, 8'h00);
        for (int i = 1; i <= 5; i++) io_write(32'h30000, 8'(i));
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", tx_valid); end
        ram_din = 8'h9E;
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (program_finish !== 1'b0) begin n_fail++; $display("FAIL mid_rst_finish: got %b want 0", program_finish); end
        n_checks++; if (cpu_din !== 8'h9E) begin n_fail++; $display("FAIL mid_rst_cpu_din: got %h want 9e", cpu_din); end
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_tx_valid: got %b want 0", tx_valid); end
        io_read(32'h30004);
        n_checks++; if (cpu_din !== 8'h03) begin n_fail++; $display("FAIL mid_post_counter: got %h want 03", cpu_din); end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_tx();
        test_tx_full();
        test_rx();
        test_rdy_low();
        test_finish();
        test_counter();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
